dca_matrix_register_stream: RTL and testbench

Parametrised matrix register with streaming row load and selectable row- or column-wise drain over valid/ready handshakes. It adds a fill counter, a load/drain FSM and a transposing drain mode. It also keeps random per-element write and full-array read. It sits between a DCA row-streaming data mover and the compute array: operand tiles fill through it, and it supplies operands either row-major or transposed.

---
 rtl/dca_matrix_register_stream.sv | 130 +++++++++++++
 tb/tb_dca_matrix_register_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_register_stream.sv
// Matrix register: row-streamed fill, row- or column-wise drain,
// plus random per-element write and full-array read.
module dca_matrix_register_stream #(
    parameter int NUM_ROW = 8,
    parameter int NUM_COL = 8,
    parameter int BW_SCALAR = 32,
    parameter logic [BW_SCALAR-1:0] RESET_VALUE = '0,
    parameter logic [BW_SCALAR-1:0] INIT_VALUE = RESET_VALUE,
    localparam int NUM_ELEM = NUM_ROW * NUM_COL,
    localparam int NUM_LANE = (NUM_ROW > NUM_COL) ? NUM_ROW : NUM_COL,
    localparam int BW_COUNT = $clog2(NUM_LANE + 1)
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          init,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_COL*BW_SCALAR-1:0]  load_data,
    input  logic                          drain_mode,
    output logic                          drain_valid,
    input  logic                          drain_ready,
    output logic [NUM_LANE*BW_SCALAR-1:0] drain_data,
    input  logic [NUM_ELEM-1:0]           all_wenable_list2d,
    input  logic [NUM_ELEM*BW_SCALAR-1:0] all_wdata_list2d,
    output logic [NUM_ELEM*BW_SCALAR-1:0] all_rdata_list2d,
    output logic                          full,
    output logic [BW_COUNT-1:0]           fill_count
);

    localparam int BW_ROW = NUM_COL * BW_SCALAR;
    localparam logic [BW_COUNT-1:0] LAST_LOAD = BW_COUNT'(NUM_ROW - 1);
    localparam logic [BW_COUNT-1:0] ROW_SLICES = BW_COUNT'(NUM_ROW);
    localparam logic [BW_COUNT-1:0] COL_SLICES = BW_COUNT'(NUM_COL);
    localparam logic [BW_COUNT-1:0] ONE = BW_COUNT'(1);

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t                          state_q;
    logic                            mode_q;
    logic [NUM_ELEM*BW_SCALAR-1:0]   arr_q;
    logic [NUM_ELEM*BW_SCALAR-1:0]   arr_d;
    logic                            load_fire;
    logic                            drain_fire;

    assign load_ready       = (state_q == LOAD) & ~init;
    assign drain_valid      = (state_q == DRAIN) & ~init;
    assign full             = (state_q == DRAIN);
    assign load_fire        = load_valid & load_ready;
    assign drain_fire       = drain_valid & drain_ready;
    assign all_rdata_list2d = arr_q;

    // A shift owns the whole array for the cycle; all-writes are dropped.
    always_comb begin
        arr_d = arr_q;
        unique case (1'b1)
            load_fire: begin
                for (int r = 0; r < NUM_ROW - 1; r++)
                    arr_d[r*BW_ROW +: BW_ROW] = arr_q[(r+1)*BW_ROW +: BW_ROW];
                arr_d[(NUM_ROW-1)*BW_ROW +: BW_ROW] = load_data;
            end
            drain_fire: begin
                if (!mode_q) begin
                    for (int r = 0; r < NUM_ROW - 1; r++)
                        arr_d[r*BW_ROW +: BW_ROW] = arr_q[(r+1)*BW_ROW +: BW_ROW];
                    arr_d[(NUM_ROW-1)*BW_ROW +: BW_ROW] = {NUM_COL{RESET_VALUE}};
                end else begin
                    for (int r = 0; r < NUM_ROW; r++) begin
                        for (int c = 0; c < NUM_COL - 1; c++)
                            arr_d[(r*NUM_COL+c)*BW_SCALAR +: BW_SCALAR] =
                                arr_q[(r*NUM_COL+c+1)*BW_SCALAR +: BW_SCALAR];
                        arr_d[(r*NUM_COL+NUM_COL-1)*BW_SCALAR +: BW_SCALAR] =
                            RESET_VALUE;
                    end
                end
            end
            default: begin
                for (int i = 0; i < NUM_ELEM; i++)
                    if (all_wenable_list2d[i])
                        arr_d[i*BW_SCALAR +: BW_SCALAR] =
                            all_wdata_list2d[i*BW_SCALAR +: BW_SCALAR];
            end
        endcase
    end

    always_comb begin
        drain_data = '0;
        if (mode_q) begin
            for (int r = 0; r < NUM_ROW; r++)
                drain_data[r*BW_SCALAR +: BW_SCALAR] =
                    arr_q[(r*NUM_COL)*BW_SCALAR +: BW_SCALAR];
        end else begin
            for (int c = 0; c < NUM_COL; c++)
                drain_data[c*BW_SCALAR +: BW_SCALAR] =
                    arr_q[c*BW_SCALAR +: BW_SCALAR];
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            arr_q      <= {NUM_ELEM{RESET_VALUE}};
            state_q    <= LOAD;
            mode_q     <= 1'b0;
            fill_count <= '0;
        end else if (init) begin
            arr_q      <= {NUM_ELEM{INIT_VALUE}};
            state_q    <= LOAD;
            mode_q     <= 1'b0;
            fill_count <= '0;
        end else begin
            arr_q <= arr_d;
            if (load_fire) begin
                if (fill_count == LAST_LOAD) begin
                    state_q    <= DRAIN;
                    mode_q     <= drain_mode;
                    fill_count <= drain_mode ? COL_SLICES : ROW_SLICES;
                end else begin
                    fill_count <= fill_count + ONE;
                end
            end else if (drain_fire) begin
                if (fill_count == ONE) begin
                    state_q    <= LOAD;
                    fill_count <= '0;
                end else begin
                    fill_count <= fill_count - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_register_stream.sv
// Scoreboard bench for dca_matrix_register_stream (4x4, 8-bit).
module tb_dca_matrix_register_stream;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int BW = 8;
    localparam int NE = NR * NC;

    logic              clk = 1'b0;
    logic              rstnn;
    logic              init;
    logic              load_valid;
    logic              load_ready;
    logic [NC*BW-1:0]  load_data;
    logic              drain_mode;
    logic              drain_valid;
    logic              drain_ready;
    logic [NC*BW-1:0]  drain_data;
    logic [NE-1:0]     wen;
    logic [NE*BW-1:0]  wdata;
    logic [NE*BW-1:0]  rdata;
    logic              full;
    logic [2:0]        fill_count;

    dca_matrix_register_stream #(
        .NUM_ROW(NR), .NUM_COL(NC), .BW_SCALAR(BW),
        .RESET_VALUE(8'h00), .INIT_VALUE(8'hFF)
    ) dut (
        .clk(clk), .rstnn(rstnn), .init(init),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .drain_mode(drain_mode),
        .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_data(drain_data),
        .all_wenable_list2d(wen), .all_wdata_list2d(wdata),
        .all_rdata_list2d(rdata), .full(full), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [7:0]  m[NR][NC];
    logic [31:0] tile[NR];
    logic        dmode;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        f = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                f[(r*NC+c)*8 +: 8] = m[r][c];
        return f;
    endfunction

    task automatic model_fill(input logic [7:0] v);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                m[r][c] = v;
    endtask

    task automatic model_row_shift(input logic [31:0] row);
        for (int r = 0; r < NR - 1; r++)
            for (int c = 0; c < NC; c++)
                m[r][c] = m[r+1][c];
        for (int c = 0; c < NC; c++)
            m[NR-1][c] = row[c*8 +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rows(input logic mode);
        for (int i = 0; i < NR; i++) begin
            load_valid = 1'b1;
            load_data  = tile[i];
            drain_mode = mode;
            #1;
            check("load_ready", 128'(load_ready), 128'(1));
            tick();
            model_row_shift(tile[i]);
            check("rdata_after_load", rdata, model_flat());
        end
        load_valid = 1'b0;
        drain_mode = ~mode;
        dmode = mode;
        check("full_after_load", 128'(full), 128'(1));
        check("fill_after_load", 128'(fill_count),
              mode ? 128'(NC) : 128'(NR));
        check("drain_valid_after_load", 128'(drain_valid), 128'(1));
        if (!mode) begin
            for (int r = 0; r < NR; r++)
                sb.push_back({m[r][3], m[r][2], m[r][1], m[r][0]});
        end else begin
            for (int c = 0; c < NC; c++)
                sb.push_back({m[3][c], m[2][c], m[1][c], m[0][c]});
        end
    endtask

    task automatic drain(input logic [5:0] pat, input bit toggle,
                         input int n);
        int cyc = 0;
        int pops = 0;
        while (pops < n && sb.size() > 0 && cyc < 40) begin
            drain_ready = pat[cyc % 6];
            if (toggle) drain_mode = ~drain_mode;
            #1;
            check("drain_valid", 128'(drain_valid), 128'(1));
            check("drain_data", 128'(drain_data), 128'(sb[0]));
            tick();
            if (drain_ready) begin
                void'(sb.pop_front());
                pops++;
                for (int r = 0; r < NR; r++)
                    for (int c = 0; c < NC; c++) begin
                        if (!dmode)
                            m[r][c] = (r < NR-1) ? m[r+1][c] : 8'h00;
                        else
                            m[r][c] = (c < NC-1) ? m[r][c+1] : 8'h00;
                    end
            end
            cyc++;
        end
        drain_ready = 1'b0;
        if (pops < n)
            check("drain_timeout", 128'(pops), 128'(n));
        check("rdata_after_drain", rdata, model_flat());
        if (sb.size() == 0) begin
            check("load_ready_after_drain", 128'(load_ready), 128'(1));
            check("fill_after_drain", 128'(fill_count), 128'(0));
            check("full_after_drain", 128'(full), 128'(0));
        end
    endtask

    initial begin
        rstnn = 1'b1;
        init = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        drain_mode = 1'b0;
        drain_ready = 1'b0;
        wen = '0;
        wdata = '0;
        dmode = 1'b0;
        model_fill(8'h00);
        tile[0] = 32'h03020100;
        tile[1] = 32'h07060504;
        tile[2] = 32'h0B0A0908;
        tile[3] = 32'h0F0E0D0C;

        #2 rstnn = 1'b0;
        #10;
        check("rst_load_ready", 128'(load_ready), 128'(1));
        check("rst_drain_valid", 128'(drain_valid), 128'(0));
        check("rst_full", 128'(full), 128'(0));
        check("rst_fill", 128'(fill_count), 128'(0));
        check("rst_rdata", rdata, 128'(0));
        check("rst_drain_data", 128'(drain_data), 128'(0));
        rstnn = 1'b1;
        tick();

        load_rows(1'b0);
        check("elem00", 128'(rdata[7:0]), 128'(8'h00));
        check("elem33", 128'(rdata[127:120]), 128'(8'h0F));
        drain(6'b101101, 1'b0, NR);

        load_rows(1'b1);
        drain(6'b111111, 1'b1, NC);

        load_rows(1'b0);
        drain(6'b111111, 1'b0, 2);
        init = 1'b1;
        drain_ready = 1'b1;
        #1;
        check("init_drain_valid", 128'(drain_valid), 128'(0));
        check("init_load_ready", 128'(load_ready), 128'(0));
        tick();
        init = 1'b0;
        drain_ready = 1'b0;
        sb.delete();
        model_fill(8'hFF);
        #1;
        check("init_fill", 128'(fill_count), 128'(0));
        check("init_full", 128'(full), 128'(0));
        check("init_load_ready_after", 128'(load_ready), 128'(1));
        check("init_rdata", rdata, model_flat());

        load_valid = 1'b1;
        load_data = 32'h44332211;
        wen = 16'h0020;
        wdata[5*8 +: 8] = 8'hAA;
        tick();
        load_valid = 1'b0;
        model_row_shift(32'h44332211);
        check("wr_vs_load_elem5", 128'(rdata[47:40]), 128'(m[1][1]));
        check("wr_vs_load_rdata", rdata, model_flat());
        tick();
        wen = '0;
        m[1][1] = 8'hAA;
        check("wr_idle_rdata", rdata, model_flat());
        check("wr_idle_fill", 128'(fill_count), 128'(1));

        init = 1'b1;
        tick();
        init = 1'b0;
        model_fill(8'hFF);
        load_rows(1'b0);
        drain_ready = 1'b1;
        tick();
        #2 rstnn = 1'b0;
        #1;
        check("midrst_load_ready", 128'(load_ready), 128'(1));
        check("midrst_drain_valid", 128'(drain_valid), 128'(0));
        check("midrst_fill", 128'(fill_count), 128'(0));
        check("midrst_full", 128'(full), 128'(0));
        check("midrst_rdata", rdata, 128'(0));
        sb.delete();
        drain_ready = 1'b0;
        #5 rstnn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
